// File: rtl/z80_regs_pkg.sv
// Shared command codes, register indices and flag bit positions for the
// banked Z80 register file.
package z80_regs_pkg;

    typedef enum logic [2:0] {
        CMD_NOPE   = 3'd0,
        CMD_EXDEHL = 3'd1,
        CMD_EXAF   = 3'd2,
        CMD_EXX    = 3'd3,
        CMD_INC    = 3'd4,
        CMD_DEC    = 3'd5
    } cmd_e;

    // 16-bit register indices on reg_n
    localparam logic [2:0] REG_BC = 3'd0;
    localparam logic [2:0] REG_DE = 3'd1;
    localparam logic [2:0] REG_HL = 3'd2;
    localparam logic [2:0] REG_SP = 3'd3;
    localparam logic [2:0] REG_AF = 3'd4;

    // 8-bit register indices on reg_n
    localparam logic [2:0] R8_B = 3'd0;
    localparam logic [2:0] R8_C = 3'd1;
    localparam logic [2:0] R8_D = 3'd2;
    localparam logic [2:0] R8_E = 3'd3;
    localparam logic [2:0] R8_H = 3'd4;
    localparam logic [2:0] R8_L = 3'd5;
    localparam logic [2:0] R8_F = 3'd6;
    localparam logic [2:0] R8_A = 3'd7;

    // Flag bit positions in F
    localparam int unsigned FLAG_S = 7;
    localparam int unsigned FLAG_Z = 6;
    localparam int unsigned FLAG_P = 2;
    localparam int unsigned FLAG_C = 0;

    // Raw codes 6/7 are reserved and behave as no command.
    function automatic cmd_e decode_cmd(input logic [2:0] raw);
        case (raw)
            3'd1:    return CMD_EXDEHL;
            3'd2:    return CMD_EXAF;
            3'd3:    return CMD_EXX;
            3'd4:    return CMD_INC;
            3'd5:    return CMD_DEC;
            default: return CMD_NOPE;
        endcase
    endfunction

endpackage

// File: rtl/z80_regs_banked_if.sv
// Bus between the core decode/ALU (master) and the register file (slave).
interface z80_regs_banked_if;
    logic [7:0]  opcode;
    logic [2:0]  cmd;
    logic        reg_w;
    logic        reg_b;
    logic [2:0]  reg_n;
    logic [15:0] wdata;
    logic        flg_w;
    logic [7:0]  flag;
    logic        ir_w;
    logic        ir_sel;
    logic        m1;
    logic        pe;
    logic        pem;

    logic [7:0]  reg_r8;
    logic [15:0] reg_r16;
    logic [7:0]  a;
    logic [7:0]  f;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] sp;
    logic [7:0]  i_reg;
    logic [7:0]  r_reg;
    logic        bc_nz;
    logic        cc;
    logic        ccc;

    modport master (
        output opcode, cmd, reg_w, reg_b, reg_n, wdata, flg_w, flag,
               ir_w, ir_sel, m1, pe, pem,
        input  reg_r8, reg_r16, a, f, bc, de, hl, sp, i_reg, r_reg,
               bc_nz, cc, ccc
    );

    modport slave (
        input  opcode, cmd, reg_w, reg_b, reg_n, wdata, flg_w, flag,
               ir_w, ir_sel, m1, pe, pem,
        output reg_r8, reg_r16, a, f, bc, de, hl, sp, i_reg, r_reg,
               bc_nz, cc, ccc
    );
endinterface

// File: rtl/z80_regs_bank.sv
// BANKS-deep BC/DE/HL storage selected by a rotating pointer, with the
// EXX / EX DE,HL / block INC/DEC operations and the registered BC!=0 status.
module z80_regs_bank
    import z80_regs_pkg::*;
#(
    parameter int unsigned BANKS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  cmd_e        cmd_i,
    input  logic [1:0]  bc_we_i,
    input  logic [1:0]  de_we_i,
    input  logic [1:0]  hl_we_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] bc_o,
    output logic [15:0] de_o,
    output logic [15:0] hl_o,
    output logic        bc_nz_o
);

    localparam int unsigned PTR_W = $clog2(BANKS);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [15:0]      bc_q [BANKS];
    logic [15:0]      de_q [BANKS];
    logic [15:0]      hl_q [BANKS];
    logic [15:0]      bc_d, de_d, hl_d;
    logic             bc_nz_q, bc_nz_d;

    assign bc_o    = bc_q[ptr_q];
    assign de_o    = de_q[ptr_q];
    assign hl_o    = hl_q[ptr_q];
    assign bc_nz_o = bc_nz_q;

    // Next state of the current bank; only the active bank ever changes.
    always_comb begin
        ptr_d   = ptr_q;
        bc_d    = bc_o;
        de_d    = de_o;
        hl_d    = hl_o;
        bc_nz_d = bc_nz_q;
        case (cmd_i)
            CMD_EXX: ptr_d = ptr_q + 1'b1;
            CMD_EXDEHL: begin
                de_d = hl_o;
                hl_d = de_o;
            end
            CMD_INC: begin
                bc_d    = bc_o - 16'd1;
                de_d    = de_o + 16'd1;
                hl_d    = hl_o + 16'd1;
                bc_nz_d = (bc_d != '0);
            end
            CMD_DEC: begin
                bc_d    = bc_o - 16'd1;
                de_d    = de_o - 16'd1;
                hl_d    = hl_o - 16'd1;
                bc_nz_d = (bc_d != '0);
            end
            CMD_EXAF: ;
            default: begin
                if (bc_we_i[1]) bc_d[15:8] = wdata_i[15:8];
                if (bc_we_i[0]) bc_d[7:0]  = wdata_i[7:0];
                if (de_we_i[1]) de_d[15:8] = wdata_i[15:8];
                if (de_we_i[0]) de_d[7:0]  = wdata_i[7:0];
                if (hl_we_i[1]) hl_d[15:8] = wdata_i[15:8];
                if (hl_we_i[0]) hl_d[7:0]  = wdata_i[7:0];
            end
        endcase
    end

    // Bank storage and pointer update on the falling clock edge.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < BANKS; k++) begin
                bc_q[k[PTR_W-1:0]] <= '0;
                de_q[k[PTR_W-1:0]] <= '0;
                hl_q[k[PTR_W-1:0]] <= '0;
            end
            ptr_q   <= '0;
            bc_nz_q <= 1'b0;
        end else begin
            bc_q[ptr_q] <= bc_d;
            de_q[ptr_q] <= de_d;
            hl_q[ptr_q] <= hl_d;
            ptr_q       <= ptr_d;
            bc_nz_q     <= bc_nz_d;
        end
    end

endmodule

// File: rtl/z80_regs_banked.sv
// Banked Z80 register file: A/F banks, SP, IX/IY, I/R with refresh counter,
// read ports and JR/JP/CALL/RET condition decode. BC/DE/HL live in
// z80_regs_bank.
module z80_regs_banked
    import z80_regs_pkg::*;
#(
    parameter int unsigned BANKS    = 2,
    parameter int unsigned AF_BANKS = 2,
    parameter logic [15:0] SP_RESET = 16'hDFF0,
    parameter logic [15:0] IX_RESET = 16'h0000,
    parameter logic [15:0] IY_RESET = 16'h0000
) (
    input logic               pin_clk,
    input logic               pin_rst,
    z80_regs_banked_if.slave  bus
);

    localparam int unsigned AF_W = $clog2(AF_BANKS);

    cmd_e        cmd;
    logic        wr_ok, wr16, wr8;
    logic [15:0] wdata_m;
    logic [1:0]  bc_we, de_we, hlx_we, hl_we, ix_we, iy_we;

    logic [AF_W-1:0] af_ptr_q, af_ptr_d;
    logic [7:0]      a_q [AF_BANKS];
    logic [7:0]      f_q [AF_BANKS];
    logic [7:0]      a_d, f_d;
    logic [15:0]     sp_q, sp_d, ix_q, ix_d, iy_q, iy_d;
    logic [7:0]      i_q, i_d, r_q, r_d;
    logic [15:0]     hl_plain, hl_eff;
    logic            z_fl, c_fl, p_fl, s_fl, jr_bit, jp_bit;

    assign cmd     = decode_cmd(bus.cmd);
    assign wr_ok   = (cmd == CMD_NOPE);
    assign wr16    = wr_ok & bus.reg_w;
    assign wr8     = wr_ok & ~bus.reg_w & bus.reg_b;
    // Byte writes replicate the byte so either half of a pair can take it.
    assign wdata_m = wr16 ? bus.wdata : {2{bus.wdata[7:0]}};

    // Byte-lane write enables; H/L/HL are steered to IX/IY under a prefix.
    always_comb begin
        bc_we  = '0;
        de_we  = '0;
        hlx_we = '0;
        if (wr16) begin
            if (bus.reg_n == REG_BC) bc_we  = 2'b11;
            if (bus.reg_n == REG_DE) de_we  = 2'b11;
            if (bus.reg_n == REG_HL) hlx_we = 2'b11;
        end else if (wr8) begin
            if (bus.reg_n == R8_B) bc_we  = 2'b10;
            if (bus.reg_n == R8_C) bc_we  = 2'b01;
            if (bus.reg_n == R8_D) de_we  = 2'b10;
            if (bus.reg_n == R8_E) de_we  = 2'b01;
            if (bus.reg_n == R8_H) hlx_we = 2'b10;
            if (bus.reg_n == R8_L) hlx_we = 2'b01;
        end
        hl_we = bus.pe               ? 2'b00 : hlx_we;
        ix_we = (bus.pe & ~bus.pem)  ? hlx_we : 2'b00;
        iy_we = (bus.pe &  bus.pem)  ? hlx_we : 2'b00;
    end

    z80_regs_bank #(
        .BANKS (BANKS)
    ) u_bank (
        .clk_i   (pin_clk),
        .rst_i   (pin_rst),
        .cmd_i   (cmd),
        .bc_we_i (bc_we),
        .de_we_i (de_we),
        .hl_we_i (hl_we),
        .wdata_i (wdata_m),
        .bc_o    (bus.bc),
        .de_o    (bus.de),
        .hl_o    (hl_plain),
        .bc_nz_o (bus.bc_nz)
    );

    // Next state for A/F bank, SP, IX/IY and I/R.
    always_comb begin
        af_ptr_d = af_ptr_q;
        a_d      = a_q[af_ptr_q];
        f_d      = f_q[af_ptr_q];
        sp_d     = sp_q;
        ix_d     = ix_q;
        iy_d     = iy_q;
        i_d      = i_q;
        r_d      = r_q;
        if (cmd == CMD_EXAF) af_ptr_d = af_ptr_q + 1'b1;
        if (wr16 && bus.reg_n == REG_SP) sp_d = bus.wdata;
        if (wr16 && bus.reg_n == REG_AF) begin
            a_d = bus.wdata[15:8];
            f_d = bus.wdata[7:0];
        end
        if (wr8 && bus.reg_n == R8_A) a_d = bus.wdata[7:0];
        if (wr_ok && bus.flg_w) f_d = bus.flag;
        if (ix_we[1]) ix_d[15:8] = wdata_m[15:8];
        if (ix_we[0]) ix_d[7:0]  = wdata_m[7:0];
        if (iy_we[1]) iy_d[15:8] = wdata_m[15:8];
        if (iy_we[0]) iy_d[7:0]  = wdata_m[7:0];
        if (bus.ir_w && !bus.ir_sel) i_d = bus.wdata[7:0];
        if (bus.ir_w && bus.ir_sel) r_d = bus.wdata[7:0];
        else if (bus.m1)            r_d = {r_q[7], r_q[6:0] + 7'd1};
    end

    // Register update on the falling clock edge.
    always_ff @(negedge pin_clk) begin
        if (pin_rst) begin
            for (int unsigned k = 0; k < AF_BANKS; k++) begin
                a_q[k[AF_W-1:0]] <= '0;
                f_q[k[AF_W-1:0]] <= '0;
            end
            af_ptr_q <= '0;
            sp_q     <= SP_RESET;
            ix_q     <= IX_RESET;
            iy_q     <= IY_RESET;
            i_q      <= '0;
            r_q      <= '0;
        end else begin
            a_q[af_ptr_q] <= a_d;
            f_q[af_ptr_q] <= f_d;
            af_ptr_q      <= af_ptr_d;
            sp_q          <= sp_d;
            ix_q          <= ix_d;
            iy_q          <= iy_d;
            i_q           <= i_d;
            r_q           <= r_d;
        end
    end

    assign hl_eff    = bus.pe ? (bus.pem ? iy_q : ix_q) : hl_plain;
    assign bus.hl    = hl_eff;
    assign bus.a     = a_q[af_ptr_q];
    assign bus.f     = f_q[af_ptr_q];
    assign bus.sp    = sp_q;
    assign bus.i_reg = i_q;
    assign bus.r_reg = r_q;

    // Combinational read ports.
    always_comb begin
        case (bus.reg_n)
            R8_B:    bus.reg_r8 = bus.bc[15:8];
            R8_C:    bus.reg_r8 = bus.bc[7:0];
            R8_D:    bus.reg_r8 = bus.de[15:8];
            R8_E:    bus.reg_r8 = bus.de[7:0];
            R8_H:    bus.reg_r8 = hl_eff[15:8];
            R8_L:    bus.reg_r8 = hl_eff[7:0];
            R8_F:    bus.reg_r8 = bus.f;
            default: bus.reg_r8 = bus.a;
        endcase
        case (bus.reg_n)
            REG_BC:  bus.reg_r16 = bus.bc;
            REG_DE:  bus.reg_r16 = bus.de;
            REG_HL:  bus.reg_r16 = hl_eff;
            REG_SP:  bus.reg_r16 = sp_q;
            REG_AF:  bus.reg_r16 = {bus.a, bus.f};
            default: bus.reg_r16 = '0;
        endcase
    end

    // Branch condition decode from current flags.
    always_comb begin
        z_fl = bus.f[FLAG_Z];
        c_fl = bus.f[FLAG_C];
        p_fl = bus.f[FLAG_P];
        s_fl = bus.f[FLAG_S];
        jr_bit = bus.opcode[4] ? c_fl : z_fl;
        case (bus.opcode[5:4])
            2'd0:    jp_bit = z_fl;
            2'd1:    jp_bit = c_fl;
            2'd2:    jp_bit = p_fl;
            default: jp_bit = s_fl;
        endcase
        bus.cc  = (bus.opcode == 8'h18) || (jr_bit == bus.opcode[3]);
        bus.ccc = (bus.opcode == 8'hC9) || (bus.opcode == 8'hC3) ||
                  (bus.opcode == 8'hCD) || (jp_bit == bus.opcode[3]);
    end

endmodule

// File: tb/tb_z80_regs_banked.sv
// Directed plus randomized bench for z80_regs_banked with a behavioural model.
module tb_z80_regs_banked;

    localparam int BK  = 4;
    localparam int AFB = 4;

    logic pin_clk = 1'b0;
    logic pin_rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 pin_clk = ~pin_clk;

    z80_regs_banked_if bus ();

    z80_regs_banked #(
        .BANKS    (BK),
        .AF_BANKS (AFB),
        .SP_RESET (16'hDFF0),
        .IX_RESET (16'h0000),
        .IY_RESET (16'h0000)
    ) dut (
        .pin_clk (pin_clk),
        .pin_rst (pin_rst),
        .bus     (bus)
    );

    // Reference model state
    logic [15:0] mbc[$], mde[$], mhl[$];
    logic [7:0]  ma[$], mf[$];
    int          mptr, aptr;
    logic [15:0] msp, mix, miy;
    logic [7:0]  mi, mr;
    logic        mnz;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_hl_eff();
        if (bus.pe) return bus.pem ? miy : mix;
        return mhl[mptr];
    endfunction

    task automatic m_put_hl(input logic [15:0] v);
        if (bus.pe) begin
            if (bus.pem) miy = v;
            else         mix = v;
        end else begin
            mhl[mptr] = v;
        end
    endtask

    task automatic model_edge();
        logic [15:0] t;
        if (pin_rst) begin
            mbc.delete(); mde.delete(); mhl.delete(); ma.delete(); mf.delete();
            for (int k = 0; k < BK; k++) begin
                mbc.push_back(16'h0); mde.push_back(16'h0); mhl.push_back(16'h0);
            end
            for (int k = 0; k < AFB; k++) begin
                ma.push_back(8'h0); mf.push_back(8'h0);
            end
            mptr = 0; aptr = 0;
            msp = 16'hDFF0; mix = 16'h0; miy = 16'h0;
            mi = 8'h0; mr = 8'h0; mnz = 1'b0;
            return;
        end
        if (bus.ir_w && !bus.ir_sel) mi = bus.wdata[7:0];
        if (bus.ir_w && bus.ir_sel) mr = bus.wdata[7:0];
        else if (bus.m1) mr = (mr & 8'h80) | ((mr + 8'd1) & 8'h7F);
        case (bus.cmd)
            3'd1: begin
                t = mde[mptr]; mde[mptr] = mhl[mptr]; mhl[mptr] = t;
            end
            3'd2: aptr = (aptr + 1) % AFB;
            3'd3: mptr = (mptr + 1) % BK;
            3'd4, 3'd5: begin
                mbc[mptr] = mbc[mptr] - 16'd1;
                if (bus.cmd == 3'd4) begin
                    mde[mptr] = mde[mptr] + 16'd1; mhl[mptr] = mhl[mptr] + 16'd1;
                end else begin
                    mde[mptr] = mde[mptr] - 16'd1; mhl[mptr] = mhl[mptr] - 16'd1;
                end
                mnz = (mbc[mptr] != 16'h0);
            end
            default: begin
                if (bus.reg_w) begin
                    case (bus.reg_n)
                        3'd0: mbc[mptr] = bus.wdata;
                        3'd1: mde[mptr] = bus.wdata;
                        3'd2: m_put_hl(bus.wdata);
                        3'd3: msp = bus.wdata;
                        3'd4: begin ma[aptr] = bus.wdata[15:8]; mf[aptr] = bus.wdata[7:0]; end
                        default: ;
                    endcase
                end else if (bus.reg_b) begin
                    case (bus.reg_n)
                        3'd0: begin t = mbc[mptr]; t[15:8] = bus.wdata[7:0]; mbc[mptr] = t; end
                        3'd1: begin t = mbc[mptr]; t[7:0]  = bus.wdata[7:0]; mbc[mptr] = t; end
                        3'd2: begin t = mde[mptr]; t[15:8] = bus.wdata[7:0]; mde[mptr] = t; end
                        3'd3: begin t = mde[mptr]; t[7:0]  = bus.wdata[7:0]; mde[mptr] = t; end
                        3'd4: begin t = m_hl_eff(); t[15:8] = bus.wdata[7:0]; m_put_hl(t); end
                        3'd5: begin t = m_hl_eff(); t[7:0]  = bus.wdata[7:0]; m_put_hl(t); end
                        3'd7: ma[aptr] = bus.wdata[7:0];
                        default: ;
                    endcase
                end
                if (bus.flg_w) mf[aptr] = bus.flag;
            end
        endcase
    endtask

    task automatic check_all();
        logic [15:0] ehl, ebc, ede, e16;
        logic [7:0]  ea, ef, e8;
        logic        fb, ecc, eccc;
        ea = ma[aptr]; ef = mf[aptr]; ehl = m_hl_eff();
        ebc = mbc[mptr]; ede = mde[mptr];
        case (bus.reg_n)
            3'd0: e8 = ebc[15:8];
            3'd1: e8 = ebc[7:0];
            3'd2: e8 = ede[15:8];
            3'd3: e8 = ede[7:0];
            3'd4: e8 = ehl[15:8];
            3'd5: e8 = ehl[7:0];
            3'd6: e8 = ef;
            default: e8 = ea;
        endcase
        case (bus.reg_n)
            3'd0: e16 = ebc;
            3'd1: e16 = ede;
            3'd2: e16 = ehl;
            3'd3: e16 = msp;
            3'd4: e16 = {ea, ef};
            default: e16 = 16'h0;
        endcase
        fb  = bus.opcode[4] ? ef[0] : ef[6];
        ecc = (bus.opcode == 8'h18) || (fb == bus.opcode[3]);
        case (bus.opcode[5:4])
            2'd0: fb = ef[6];
            2'd1: fb = ef[0];
            2'd2: fb = ef[2];
            default: fb = ef[7];
        endcase
        eccc = (bus.opcode == 8'hC9) || (bus.opcode == 8'hC3) ||
               (bus.opcode == 8'hCD) || (fb == bus.opcode[3]);
        chk("a",       {8'h0, bus.a},      {8'h0, ea});
        chk("f",       {8'h0, bus.f},      {8'h0, ef});
        chk("bc",      bus.bc,             ebc);
        chk("de",      bus.de,             ede);
        chk("hl",      bus.hl,             ehl);
        chk("sp",      bus.sp,             msp);
        chk("i_reg",   {8'h0, bus.i_reg},  {8'h0, mi});
        chk("r_reg",   {8'h0, bus.r_reg},  {8'h0, mr});
        chk("bc_nz",   {15'h0, bus.bc_nz}, {15'h0, mnz});
        chk("reg_r8",  {8'h0, bus.reg_r8}, {8'h0, e8});
        chk("reg_r16", bus.reg_r16,        e16);
        chk("cc",      {15'h0, bus.cc},    {15'h0, ecc});
        chk("ccc",     {15'h0, bus.ccc},   {15'h0, eccc});
    endtask

    task automatic step();
        @(negedge pin_clk);
        model_edge();
        @(posedge pin_clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        pin_rst = 1'b0;
        bus.opcode = 8'h00; bus.cmd = 3'd0; bus.reg_w = 1'b0; bus.reg_b = 1'b0;
        bus.reg_n = 3'd0; bus.wdata = 16'h0; bus.flg_w = 1'b0; bus.flag = 8'h0;
        bus.ir_w = 1'b0; bus.ir_sel = 1'b0; bus.m1 = 1'b0; bus.pe = 1'b0; bus.pem = 1'b0;
    endtask

    task automatic w16(input logic [2:0] n, input logic [15:0] d);
        idle(); bus.reg_w = 1'b1; bus.reg_n = n; bus.wdata = d; step();
    endtask

    task automatic do_cmd(input logic [2:0] c);
        idle(); bus.cmd = c; step();
    endtask

    initial begin
        idle();
        // Reset asserted together with a command: command must have no effect
        pin_rst = 1'b1; bus.cmd = 3'd4; step();
        chk("rst_a",  {8'h0, bus.a}, 16'h0000);
        chk("rst_f",  {8'h0, bus.f}, 16'h0000);
        chk("rst_bc", bus.bc, 16'h0000);
        chk("rst_de", bus.de, 16'h0000);
        chk("rst_hl", bus.hl, 16'h0000);
        chk("rst_sp", bus.sp, 16'hDFF0);
        chk("rst_r",  {8'h0, bus.r_reg}, 16'h0000);
        chk("rst_nz", {15'h0, bus.bc_nz}, 16'h0000);

        // Bank rotation with four banks
        w16(3'd0, 16'h1111);
        do_cmd(3'd3);
        w16(3'd0, 16'h2222);
        do_cmd(3'd3); do_cmd(3'd3); do_cmd(3'd3);
        chk("exx_wrap_bc", bus.bc, 16'h1111);
        do_cmd(3'd3);
        chk("exx_next_bc", bus.bc, 16'h2222);

        // Block INC/DEC and bc_nz
        w16(3'd0, 16'h0001); w16(3'd1, 16'h4000); w16(3'd2, 16'h8000);
        do_cmd(3'd4);
        chk("inc_bc", bus.bc, 16'h0000);
        chk("inc_de", bus.de, 16'h4001);
        chk("inc_hl", bus.hl, 16'h8001);
        chk("inc_nz", {15'h0, bus.bc_nz}, 16'h0000);
        do_cmd(3'd5);
        chk("dec_bc", bus.bc, 16'hFFFF);
        chk("dec_nz", {15'h0, bus.bc_nz}, 16'h0001);

        // Index prefix redirection and EX DE,HL ignoring the prefix
        idle(); bus.pe = 1'b1; bus.pem = 1'b1; bus.reg_w = 1'b1; bus.reg_n = 3'd2;
        bus.wdata = 16'hABCD; step();
        chk("iy_hl", bus.hl, 16'hABCD);
        idle(); step();
        chk("plain_hl", bus.hl, 16'h8000);
        idle(); bus.pe = 1'b1; bus.pem = 1'b1; bus.cmd = 3'd1; step();
        chk("exdehl_iy_kept", bus.hl, 16'hABCD);
        idle(); step();
        chk("exdehl_de", bus.de, 16'h8000);
        chk("exdehl_hl", bus.hl, 16'h4000);
        idle(); bus.pe = 1'b1; step();
        chk("ix_hl", bus.hl, 16'h0000);

        // R refresh counter and I write
        idle(); bus.ir_w = 1'b1; bus.ir_sel = 1'b1; bus.wdata = 16'h007F; step();
        idle(); bus.m1 = 1'b1; step();
        chk("r_7f_m1", {8'h0, bus.r_reg}, 16'h0000);
        idle(); bus.ir_w = 1'b1; bus.ir_sel = 1'b1; bus.wdata = 16'h00FF; step();
        idle(); bus.m1 = 1'b1; step();
        chk("r_ff_m1", {8'h0, bus.r_reg}, 16'h0080);
        idle(); bus.m1 = 1'b1; bus.ir_w = 1'b1; bus.ir_sel = 1'b1; bus.wdata = 16'h0055; step();
        chk("r_wr_wins", {8'h0, bus.r_reg}, 16'h0055);
        idle(); bus.ir_w = 1'b1; bus.wdata = 16'h00A5; step();
        chk("i_wr", {8'h0, bus.i_reg}, 16'h00A5);

        // Conditions and flag override
        idle(); bus.flg_w = 1'b1; bus.flag = 8'h40; step();
        idle(); bus.opcode = 8'h28; step();
        chk("cc_28", {15'h0, bus.cc}, 16'h0001);
        idle(); bus.opcode = 8'hC2; step();
        chk("ccc_c2", {15'h0, bus.ccc}, 16'h0000);
        idle(); bus.opcode = 8'hC3; step();
        chk("ccc_c3", {15'h0, bus.ccc}, 16'h0001);
        idle(); bus.reg_w = 1'b1; bus.reg_n = 3'd4; bus.wdata = 16'h1234;
        bus.flg_w = 1'b1; bus.flag = 8'hFF; step();
        chk("af_a", {8'h0, bus.a}, 16'h0012);
        chk("af_f", {8'h0, bus.f}, 16'h00FF);
        do_cmd(3'd2);
        chk("exaf_a", {8'h0, bus.a}, 16'h0000);
        do_cmd(3'd2); do_cmd(3'd2); do_cmd(3'd2);
        chk("exaf_back_a", {8'h0, bus.a}, 16'h0012);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            pin_rst    = ($urandom_range(0, 63) == 0);
            bus.cmd    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            bus.reg_w  = ($urandom_range(0, 2) == 0);
            bus.reg_b  = ($urandom_range(0, 2) == 0);
            bus.reg_n  = 3'($urandom_range(0, 7));
            bus.wdata  = 16'($urandom);
            bus.flg_w  = ($urandom_range(0, 3) == 0);
            bus.flag   = 8'($urandom);
            bus.ir_w   = ($urandom_range(0, 7) == 0);
            bus.ir_sel = 1'($urandom_range(0, 1));
            bus.m1     = 1'($urandom_range(0, 1));
            bus.pe     = ($urandom_range(0, 3) == 0);
            bus.pem    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       bus.opcode = 8'h18;
                1:       bus.opcode = 8'hC9;
                2:       bus.opcode = 8'hCD;
                default: bus.opcode = 8'($urandom);
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/z80_regs_banked.md
Name: z80_regs_banked

Overview:
Parametrised successor to the Z80 core register file. It holds A/F, BC/DE/HL, SP, IX/IY, I and R. Alternate sets are generalised to BANKS main banks and AF_BANKS accumulator banks, selected by rotating bank pointers. It adds the I/R registers with a hardware refresh counter and a registered block-transfer status. It sits beside the core's decode/ALU and provides the register read ports and the JR/JP/CALL/RET condition signals.

Parameters:
BANKS, 2, number of BC/DE/HL banks; power of two, >=2; EXX rotates through them
AF_BANKS, 2, number of A/F banks; power of two, >=2; EX AF,AF' rotates through them
SP_RESET, 16'hDFF0, SP value after reset
IX_RESET, 16'h0000, IX value after reset
IY_RESET, 16'h0000, IY value after reset

Ports:
pin_clk  in  1  clock; all state updates on falling edge
pin_rst  in  1  synchronous reset, active-high
opcode  in  8  current opcode, used for condition decode
cmd  in  3  special command: NOPE=0, EXDEHL=1, EXAF=2, EXX=3, INC=4, DEC=5; 6/7 treated as NOPE
reg_w  in  1  16-bit write strobe
reg_b  in  1  8-bit write strobe
reg_n  in  3  register index: r8 B,C,D,E,H,L,F,A / r16 BC,DE,HL,SP,AF
wdata  in  16  write data; 8-bit writes use [7:0]
flg_w  in  1  flag write strobe
flag  in  8  flag value
ir_w  in  1  I/R write strobe
ir_sel  in  1  0=I, 1=R
m1  in  1  opcode-fetch strobe; increments R
pe  in  1  index prefix active
pem  in  1  0=IX, 1=IY
reg_r8  out  8  8-bit read by reg_n, combinational
reg_r16  out  16  16-bit read by reg_n; 0 for index >4
a, f  out  8 each  current-bank A and F
bc, de, sp  out  16 each  current values
hl  out  16  IY if pe&pem, IX if pe&~pem, else HL
i_reg, r_reg  out  8 each  I and R
bc_nz  out  1  registered; 1 when BC is nonzero after the last INC/DEC
cc, ccc  out  1 each  JR condition; JP/CALL/RET condition (unconditional forms give 1)

Behaviour:
- Reset: every bank's BC/DE/HL = 0; every AF bank = 0000; both bank pointers = 0; SP=SP_RESET; IX=IX_RESET; IY=IY_RESET; I=R=0; bc_nz=0.
- Priority per edge: reset > cmd≠NOPE > reg_w > reg_b. flg_w is honoured only when cmd=NOPE and overrides F from a same-cycle reg_w to AF.
- EXX: main pointer = (ptr+1) mod BANKS. No data moves; the outputs switch to the new bank on the same edge.
- EXAF: AF pointer = (ptr+1) mod AF_BANKS.
- EXDEHL: swaps DE and HL of the current bank. It always uses HL, never IX/IY, regardless of pe.
- INC: BC-1, DE+1, HL+1, all 16-bit wrap. DEC: BC-1, DE-1, HL-1. Both use the current bank and plain HL. bc_nz <= (BC-1)!=0 on the same edge. With BC=0000, BC wraps to FFFF and bc_nz=1.
- H/L/HL writes go to IX/IY when pe=1; reg_n=6 with reg_b is ignored.
- R refresh: on m1, R[6:0] increments mod 128 and R[7] is held. An ir_w to R in the same cycle wins, loading the full 8 bits.
- cc: Z vs opcode[3] when opcode[4]=0; C vs opcode[3] when opcode[4]=1; also 1 for 18h.
- ccc: opcode[5:4] selects Z/C/P/S vs opcode[3]; also 1 for C9h, C3h, CDh.
- Flag bits: S=7, Z=6, P=2, C=0.
- Reads are combinational from current bank state, so a value written is visible after the edge.
- Reset asserted during any command: state returns to reset values and the command has no effect.

Decomposition:
- Package z80_regs_pkg: CMD_* codes, REG_BC..REG_AF indices, FLAG_* bit positions.
- One sub-module z80_regs_bank: BANKS-deep BC/DE/HL storage with rotating pointer, INC/DEC/EXDEHL logic and bc_nz. The top level holds AF banks, SP, IX/IY, I/R and the condition logic.

Test Plan:
- Reset, then read all ports -> A=00, F=00, BC=DE=HL=0000, SP=DFF0, R=00, bc_nz=0.
- BANKS=4: write BC=1111, EXX, write BC=2222, EXX×3 -> BC=1111; one more EXX -> BC=2222.
- BC=0001, DE=4000, HL=8000, cmd=INC -> BC=0000, DE=4001, HL=8001, bc_nz=0. DEC from BC=0000 -> BC=FFFF, bc_nz=1.
- pe=1, pem=1, reg_w HL=ABCD -> hl=ABCD; pe=0 -> hl shows the old HL. EXDEHL with pe=1 swaps plain HL only.
- R=7F, m1 -> R=00. R=FF, m1 -> R=80. m1 together with ir_w R=55 -> R=55.
- F=40, opcode=28h -> cc=1; opcode=C2h -> ccc=0; opcode=C3h -> ccc=1. reg_w AF=1234 with flg_w flag=FF -> A=12, F=FF.
